// File: rtl/gyro_reset_sequencer_pkg.sv
// Shared definitions for the gyro reset sequencer: FSM states, register
// addresses and the bit positions inside CTRL and STATUS.
package gyro_rst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SETTLE = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PULSE  = 2'd1;
    localparam logic [1:0] ADDR_SETTLE = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_AUTO_EN = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_READY    = 1;
    localparam int STAT_DONE     = 2;
    localparam int STAT_FAIL     = 3;
    localparam int STAT_RCNT_LSB = 4;

endpackage

// File: rtl/gyro_reset_sequencer_fault_sync.sv
// Two-flop synchronizer bringing the gyro's asynchronous fault flag into
// the clk domain. Clears to 0 on reset so no spurious fault is seen.
module gyro_fault_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [1:0] stage_reg;

    // Shift the asynchronous level through two flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_reg <= 2'b00;
        end else begin
            stage_reg <= {stage_reg[0], async_in};
        end
    end

    assign sync_out = stage_reg[1];

endmodule

// File: rtl/gyro_reset_sequencer.sv
// Gyro reset sequencer: Avalon-MM slave driving the gyro's active-low
// reset. Runs pulse -> settle -> ready after power-on, on START, and
// (optionally) after gyro faults with a bounded number of retries.
module gyro_reset_sequencer
    import gyro_rst_pkg::*;
#(
    parameter int CNT_W          = 24,
    parameter int PULSE_DEFAULT  = 50000,
    parameter int SETTLE_DEFAULT = 500000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        gyro_fault,
    output logic        gyro_rst_n,
    output logic        gyro_ready,
    output logic        irq
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Register file
    logic [CNT_W-1:0]   pulse_len_reg;
    logic [CNT_W-1:0]   settle_len_reg;
    logic               auto_en_reg;
    logic               irq_en_reg;
    logic               start_req_reg;

    // Sequencer state
    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               gyro_rst_n_reg;
    logic               gyro_ready_reg;
    logic               done_sticky_reg;
    logic               fail_reg;
    logic [RETRY_W-1:0] retry_cnt_reg;
    logic [3:0]         reset_count_reg;

    logic               fault_sync;
    logic               wr_en;
    logic               ctrl_wr;
    logic               pulse_wr;
    logic               settle_wr;
    logic               status_wr;
    logic               busy;
    logic [3:0]         reset_count_next;
    logic               unused_wdata;

    // A zero length still produces a one-cycle phase
    function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    gyro_fault_sync u_fault_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (gyro_fault),
        .sync_out (fault_sync)
    );

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en & (address == ADDR_CTRL);
    assign pulse_wr  = wr_en & (address == ADDR_PULSE);
    assign settle_wr = wr_en & (address == ADDR_SETTLE);
    assign status_wr = wr_en & (address == ADDR_STATUS);

    assign busy = (state_reg == ST_ASSERT) || (state_reg == ST_SETTLE);
    assign reset_count_next = (reset_count_reg == 4'hF) ? 4'hF : reset_count_reg + 4'd1;

    // Only a handful of writedata bits are meaningful
    assign unused_wdata = ^writedata;

    // CPU-visible configuration; START is captured as a one-cycle request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_len_reg  <= CNT_W'(PULSE_DEFAULT);
            settle_len_reg <= CNT_W'(SETTLE_DEFAULT);
            auto_en_reg    <= 1'b0;
            irq_en_reg     <= 1'b0;
            start_req_reg  <= 1'b0;
        end else begin
            start_req_reg <= ctrl_wr & writedata[CTRL_START];
            if (ctrl_wr) begin
                auto_en_reg <= writedata[CTRL_AUTO_EN];
                irq_en_reg  <= writedata[CTRL_IRQ_EN];
            end
            if (pulse_wr) begin
                pulse_len_reg <= writedata[CNT_W-1:0];
            end
            if (settle_wr) begin
                settle_len_reg <= writedata[CNT_W-1:0];
            end
        end
    end

    // Sequencer FSM with its phase counter, status flags and registered pin outputs.
    // Status write-clears are applied first so a same-cycle set or increment overrides them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_ASSERT;
            cnt_reg         <= CNT_W'(PULSE_DEFAULT);
            gyro_rst_n_reg  <= 1'b0;
            gyro_ready_reg  <= 1'b0;
            done_sticky_reg <= 1'b0;
            fail_reg        <= 1'b0;
            retry_cnt_reg   <= '0;
            reset_count_reg <= 4'd0;
        end else begin
            if (status_wr && writedata[STAT_DONE]) begin
                done_sticky_reg <= 1'b0;
            end
            if (status_wr && writedata[STAT_RCNT_LSB]) begin
                reset_count_reg <= 4'd0;
            end

            case (state_reg)
                ST_ASSERT: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg      <= ST_SETTLE;
                        cnt_reg        <= load_len(settle_len_reg);
                        gyro_rst_n_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg       <= ST_READY;
                        gyro_ready_reg  <= 1'b1;
                        done_sticky_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (start_req_reg) begin
                        state_reg       <= ST_ASSERT;
                        cnt_reg         <= load_len(pulse_len_reg);
                        gyro_rst_n_reg  <= 1'b0;
                        gyro_ready_reg  <= 1'b0;
                        retry_cnt_reg   <= '0;
                        fail_reg        <= 1'b0;
                        reset_count_reg <= reset_count_next;
                    end else if (fault_sync && auto_en_reg) begin
                        if (retry_cnt_reg < RETRY_W'(MAX_RETRY)) begin
                            state_reg       <= ST_ASSERT;
                            cnt_reg         <= load_len(pulse_len_reg);
                            gyro_rst_n_reg  <= 1'b0;
                            gyro_ready_reg  <= 1'b0;
                            retry_cnt_reg   <= retry_cnt_reg + RETRY_W'(1);
                            reset_count_reg <= reset_count_next;
                        end else begin
                            state_reg       <= ST_IDLE;
                            gyro_rst_n_reg  <= 1'b0;
                            gyro_ready_reg  <= 1'b0;
                            fail_reg        <= 1'b1;
                            done_sticky_reg <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (start_req_reg) begin
                        state_reg       <= ST_ASSERT;
                        cnt_reg         <= load_len(pulse_len_reg);
                        gyro_rst_n_reg  <= 1'b0;
                        gyro_ready_reg  <= 1'b0;
                        retry_cnt_reg   <= '0;
                        fail_reg        <= 1'b0;
                        reset_count_reg <= reset_count_next;
                    end
                end
                default: begin
                    state_reg      <= ST_ASSERT;
                    cnt_reg        <= load_len(pulse_len_reg);
                    gyro_rst_n_reg <= 1'b0;
                    gyro_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_AUTO_EN] = auto_en_reg;
                readdata[CTRL_IRQ_EN]  = irq_en_reg;
            end
            ADDR_PULSE:  readdata[CNT_W-1:0] = pulse_len_reg;
            ADDR_SETTLE: readdata[CNT_W-1:0] = settle_len_reg;
            default: begin
                readdata[STAT_BUSY]              = busy;
                readdata[STAT_READY]             = gyro_ready_reg;
                readdata[STAT_DONE]              = done_sticky_reg;
                readdata[STAT_FAIL]              = fail_reg;
                readdata[STAT_RCNT_LSB +: 4]     = reset_count_reg;
            end
        endcase
    end

    assign gyro_rst_n = gyro_rst_n_reg;
    assign gyro_ready = gyro_ready_reg;
    assign irq        = done_sticky_reg & irq_en_reg;

endmodule

// File: tb/tb_gyro_reset_sequencer.sv
// Self-checking bench for gyro_reset_sequencer: directed scenarios with
// hand-computed expectations, then randomized bus/fault traffic, all
// compared every cycle against a timeline-based behavioural model.
module tb_gyro_reset_sequencer;

    localparam int PD = 4;
    localparam int SD = 6;
    localparam int MR = 3;

    localparam int MS_SEQ    = 0;
    localparam int MS_ONLINE = 1;
    localparam int MS_HELD   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        gyro_fault = 1'b0;
    logic        gyro_rst_n;
    logic        gyro_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    gyro_reset_sequencer #(
        .CNT_W          (24),
        .PULSE_DEFAULT  (PD),
        .SETTLE_DEFAULT (SD),
        .MAX_RETRY      (MR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .gyro_fault (gyro_fault),
        .gyro_rst_n (gyro_rst_n),
        .gyro_ready (gyro_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: sequencing (elapsed time m_t since the pulse began), online, or held.
    int m_mode, m_t, m_pe, m_se, m_retry, m_rc, m_pulse, m_settle;
    bit m_auto, m_irqen, m_done, m_fail, m_start, m_f1, m_f2;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_mode = MS_SEQ; m_t = 0; m_pe = eff(PD); m_se = 1;
        m_retry = 0; m_rc = 0; m_pulse = PD; m_settle = SD;
        m_auto = 0; m_irqen = 0; m_done = 0; m_fail = 0;
        m_start = 0; m_f1 = 0; m_f2 = 0;
    endtask

    task automatic begin_seq();
        m_mode = MS_SEQ;
        m_t = 0;
        m_pe = eff(m_pulse);
    endtask

    task automatic model_step();
        bit wr, set_done, inc;
        int rcn;
        logic [31:0] wd;
        wr = chipselect && !write_n;
        wd = writedata;
        set_done = 0;
        inc = 0;
        case (m_mode)
            MS_SEQ: begin
                m_t++;
                if (m_t == m_pe) m_se = eff(m_settle);
                else if (m_t > m_pe && m_t == m_pe + m_se) begin
                    m_mode = MS_ONLINE;
                    set_done = 1;
                end
            end
            MS_ONLINE: begin
                if (m_start) begin
                    begin_seq(); m_retry = 0; m_fail = 0; inc = 1;
                end else if (m_f2 && m_auto) begin
                    if (m_retry < MR) begin
                        begin_seq(); m_retry++; inc = 1;
                    end else begin
                        m_mode = MS_HELD; m_fail = 1; set_done = 1;
                    end
                end
            end
            default: begin
                if (m_start) begin
                    begin_seq(); m_retry = 0; m_fail = 0; inc = 1;
                end
            end
        endcase
        rcn = (wr && address == 2'd3 && wd[4]) ? 0 : m_rc;
        if (inc) rcn = (m_rc >= 15) ? 15 : m_rc + 1;
        m_rc = rcn;
        if (wr && address == 2'd3 && wd[2]) m_done = 0;
        if (set_done) m_done = 1;
        m_start = wr && address == 2'd0 && wd[0];
        if (wr && address == 2'd0) begin
            m_auto = wd[1];
            m_irqen = wd[2];
        end
        if (wr && address == 2'd1) m_pulse = int'(wd[23:0]);
        if (wr && address == 2'd2) m_settle = int'(wd[23:0]);
        m_f2 = m_f1;
        m_f1 = gyro_fault;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        logic exp_rst, exp_rdy;
        logic [31:0] exp_rd;
        forever begin
            @(negedge clk);
            exp_rdy = (m_mode == MS_ONLINE);
            exp_rst = exp_rdy || (m_mode == MS_SEQ && m_t >= m_pe);
            case (address)
                2'd0: exp_rd = {29'd0, m_irqen, m_auto, 1'b0};
                2'd1: exp_rd = 32'(m_pulse);
                2'd2: exp_rd = 32'(m_settle);
                default: exp_rd = {24'd0, 4'(m_rc), m_fail, m_done, exp_rdy, (m_mode == MS_SEQ)};
            endcase
            chk("gyro_rst_n", 32'(gyro_rst_n), 32'(exp_rst));
            chk("gyro_ready", 32'(gyro_ready), 32'(exp_rdy));
            chk("irq", 32'(irq), 32'(m_done && m_irqen));
            chk("readdata", readdata, exp_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("write addr %0d data 0x%0h", a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a;
        @(negedge clk);
        d = readdata;
        $display("read  addr %0d data 0x%0h", a, d);
    endtask

    task automatic fault_pulse();
        @(posedge clk); #1 gyro_fault = 1'b1;
        @(posedge clk); #1 gyro_fault = 1'b0;
        $display("fault pulse at cycle %0d", cyc);
    endtask

    // sel 0 waits on gyro_rst_n, sel 1 on gyro_ready
    task automatic wait_out(input string name, input int sel, input logic v);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (((sel == 0) ? gyro_rst_n : gyro_ready) === v) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL timeout %s: got no level %0b want %0b", name, ~v, v);
        end
    endtask

    // Count negedges with gyro_rst_n low, then high-but-not-ready
    task automatic measure(output int low_n, output int set_n);
        int guard;
        low_n = 0; set_n = 0; guard = 0;
        @(negedge clk);
        while (gyro_rst_n !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
        while (gyro_rst_n === 1'b0 && guard < 400) begin low_n++; @(negedge clk); guard++; end
        while (gyro_rst_n === 1'b1 && gyro_ready === 1'b0 && guard < 600) begin
            set_n++; @(negedge clk); guard++;
        end
        $display("sequence measured low %0d settle %0d", low_n, set_n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        int lo, st, t0, t1, r;
        logic [1:0] a;

        // Reset values
        address = 2'd3;
        repeat (3) @(negedge clk);
        chk("rst_gyro_rst_n", 32'(gyro_rst_n), 32'd0);
        chk("rst_gyro_ready", 32'(gyro_ready), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_status", readdata, 32'h001);
        @(posedge clk); #1 reset_n = 1'b1;

        // Power-on sequence with defaults 4/6
        measure(lo, st);
        chk("por_pulse_len", 32'(lo), 32'd4);
        chk("por_settle_len", 32'(st), 32'd6);
        rd(2'd3, d);
        chk("por_status", d, 32'h006);

        // Software sequence 10/3 with irq
        wr(2'd3, 32'h4);
        wr(2'd1, 32'd10);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h5);
        measure(lo, st);
        chk("sw_pulse_len", 32'(lo), 32'd10);
        chk("sw_settle_len", 32'(st), 32'd3);
        chk("sw_irq_high", 32'(irq), 32'd1);
        rd(2'd3, d);
        chk("sw_status", d, 32'h016);
        wr(2'd3, 32'h4);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);

        // START during SETTLE is ignored
        wr(2'd2, 32'd8);
        wr(2'd0, 32'h5);
        wait_out("enter_assert", 0, 1'b0);
        wait_out("enter_settle", 0, 1'b1);
        t0 = cyc;
        wr(2'd0, 32'h5);
        wait_out("ready_after_ignored", 1, 1'b1);
        t1 = cyc;
        chk("ignored_start_settle", 32'(t1 - t0), 32'd8);
        rd(2'd3, d);
        chk("ignored_start_status", d, 32'h026);

        // Auto retries until failure
        wr(2'd1, 32'd5);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h2);
        wr(2'd3, 32'h14);
        for (int i = 0; i < 4; i++) begin
            fault_pulse();
            if (i < 3) begin
                wait_out("retry_drop", 1, 1'b0);
                wait_out("retry_ready", 1, 1'b1);
            end else begin
                wait_out("fail_hold", 0, 1'b0);
            end
        end
        repeat (4) @(negedge clk);
        chk("fail_gyro_rst_n", 32'(gyro_rst_n), 32'd0);
        rd(2'd3, d);
        chk("fail_status", d, 32'h03C);

        // START + fault in the same READY cycle
        wr(2'd0, 32'h3);
        wait_out("restart_ready", 1, 1'b1);
        fault_pulse();
        wait_out("r1_drop", 1, 1'b0);
        wait_out("r1_ready", 1, 1'b1);
        @(posedge clk); #1 gyro_fault = 1'b1;
        @(posedge clk); #1 gyro_fault = 1'b0;
        address = 2'd0; writedata = 32'h3; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1 chipselect = 1'b0; write_n = 1'b1;
        $display("start and fault coincide at cycle %0d", cyc);
        wait_out("combo_drop", 1, 1'b0);
        wait_out("combo_ready", 1, 1'b1);
        repeat (12) @(negedge clk);
        chk("combo_single_seq", 32'(gyro_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            fault_pulse();
            wait_out("post_combo_drop", 1, 1'b0);
            wait_out("post_combo_ready", 1, 1'b1);
        end
        rd(2'd3, d);
        chk("retry_cleared_fail", 32'(d[3]), 32'd0);

        // Zero-length pulse
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h1);
        measure(lo, st);
        chk("zero_pulse_len", 32'(lo), 32'd1);
        chk("zero_settle_len", 32'(st), 32'd2);

        // Reset in the middle of SETTLE
        wr(2'd2, 32'd20);
        wr(2'd0, 32'h1);
        wait_out("mid_assert", 0, 1'b0);
        wait_out("mid_settle", 0, 1'b1);
        repeat (3) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_gyro_rst_n", 32'(gyro_rst_n), 32'd0);
        chk("midreset_gyro_ready", 32'(gyro_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        measure(lo, st);
        chk("repor_pulse_len", 32'(lo), 32'd4);
        chk("repor_settle_len", 32'(st), 32'd6);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            chipselect = 1'b0; write_n = 1'b1; gyro_fault = 1'b0;
            r = $urandom_range(0, 99);
            a = 2'($urandom_range(0, 3));
            address = a;
            if (r < 6) begin
                case (a)
                    2'd0: writedata = $urandom & 32'h7;
                    2'd1, 2'd2: writedata = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 12));
                    default: writedata = $urandom;
                endcase
                chipselect = 1'b1; write_n = 1'b0;
                $display("rand write addr %0d data 0x%0h", a, writedata);
            end else if (r < 10) begin
                gyro_fault = 1'b1;
                $display("rand fault at cycle %0d", cyc);
            end
        end
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; gyro_fault = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gyro_reset_sequencer.md
# gyro_reset_sequencer

Avalon-MM slave that owns the gyro's active-low reset line and sequences it: a timed reset pulse, a settle window, then a ready indication to the CPU. It runs a power-on sequence automatically after `reset_n` and can re-run the sequence on software command or, optionally, on a hardware fault from the gyro with bounded retries. It sits between the Nios bus and the gyro reset pin and replaces direct software toggling of that pin.

## Interface
- `CNT_W`, 24: width of pulse and settle counters and length registers.
- `PULSE_DEFAULT`, 50000: reset value of PULSE_LEN, in clk cycles.
- `SETTLE_DEFAULT`, 500000: reset value of SETTLE_LEN, in clk cycles.
- `MAX_RETRY`, 3: number of automatic fault retries before declaring failure.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, zero wait states (combinational from `address`).
- `gyro_fault`  in  1  asynchronous fault/loss-of-data flag from the gyro, active-high.
- `gyro_rst_n`  out  1  reset to the gyro, active-low, registered.
- `gyro_ready`  out  1  gyro out of reset and settled, registered.
- `irq`  out  1  level interrupt, `done_sticky & IRQ_EN`.

## Operation
- Register map, where a write is `chipselect & ~write_n`:
  - 0 CTRL: bit0 START, write-1 pulse that reads as 0; bit1 AUTO_EN; bit2 IRQ_EN. The enable bits reset to 0.
  - 1 PULSE_LEN: bits `[CNT_W-1:0]`.
  - 2 SETTLE_LEN: bits `[CNT_W-1:0]`.
  - 3 STATUS: bit0 busy; bit1 ready; bit2 done_sticky, write-1-to-clear; bit3 fail; bits[7:4] reset_count, saturating at 15, write-1 to bit4 clears it. All other bits read 0.
- FSM states are IDLE, ASSERT, SETTLE and READY. Reset state is ASSERT with the counter loaded from PULSE_DEFAULT, so the power-on sequence runs automatically.
  - ASSERT: `gyro_rst_n=0`. The counter loads the length on entry and decrements each cycle. At count 1 the FSM moves to SETTLE. A length of 0 is treated as 1.
  - SETTLE: `gyro_rst_n=1`, `gyro_ready=0`. Counting follows the same rule, then the FSM moves to READY. On entry to READY, done_sticky is set.
  - READY: `gyro_rst_n=1`, `gyro_ready=1`.
  - IDLE: reached only on failure. `gyro_rst_n=0` and `gyro_ready=0`; the gyro is held in reset.
- START in READY or IDLE moves the FSM to ASSERT. It also clears retry_cnt and fail, and increments reset_count. START in ASSERT or SETTLE is ignored.
- Fault handling, using `gyro_fault` synchronized through 2 flops:
  - In READY with AUTO_EN=1 and retry_cnt < MAX_RETRY, the FSM moves to ASSERT, retry_cnt increments and reset_count increments.
  - In READY with AUTO_EN=1 and retry_cnt = MAX_RETRY, the FSM moves to IDLE, sets fail and sets done_sticky.
  - Faults in other states, or with AUTO_EN=0, are ignored.
- START and a fault in the same cycle in READY: START wins and retry_cnt is cleared.
- A write to PULSE_LEN or SETTLE_LEN mid-sequence affects the next counter load only.
- A clear of done_sticky in the same cycle it is set: the set wins.
- `reset_n` asserted mid-sequence restarts the power-on sequence immediately.

## Timing
- Reset values: `gyro_rst_n=0`, `gyro_ready=0`, `irq=0`, busy=1, reset_count=0, fail=0.
- START accepted at edge T:
  - `gyro_rst_n` falls after edge T+1 and stays low exactly PULSE_LEN cycles.
  - It then stays high for SETTLE_LEN cycles with `gyro_ready=0`.
  - `gyro_ready` and `irq` (if IRQ_EN) rise on the following edge.
- Fault-to-ASSERT latency is 3 edges from the `gyro_fault` rise: 2 for the synchronizer and 1 for the FSM.
- busy = state is ASSERT or SETTLE. Register writes take effect on the next edge.

## Structure
- Package `gyro_rst_pkg` holds the state enum, register address constants (CTRL/PULSE/SETTLE/STATUS) and the CTRL/STATUS bit positions.
- One sub-module, `gyro_fault_sync`: a 2-flop synchronizer with an async active-low reset to 0.
- FSM, counter and register file live in the top module.

## Test plan
- Power-on with PULSE_DEFAULT=4 and SETTLE_DEFAULT=6 -> `gyro_rst_n` is 0 for 4 cycles after reset release, then 1. `gyro_ready` rises 6 cycles later. STATUS reads 0x006.
- Write PULSE_LEN=10 and SETTLE_LEN=3, then CTRL=0x5 -> `gyro_rst_n` is low for 10 cycles and high for 3, then `irq`=1. STATUS reads 0x016. Writing STATUS=0x4 drops `irq`.
- START written during SETTLE -> ignored. Sequence length is unchanged and reset_count is unchanged.
- AUTO_EN=1 with 4 fault pulses, each after READY -> 3 re-sequences with reset_count=3. On the 4th fault the FSM enters IDLE: `gyro_rst_n=0` and fail=1. STATUS reads 0x03C.
- START and fault in the same READY cycle -> a single sequence runs and retry_cnt=0.
- PULSE_LEN=0 -> a 1-cycle pulse. `reset_n` asserted mid-SETTLE -> `gyro_rst_n=0` immediately and the power-on sequence restarts.
